temperature_calculator: RTL and testbench
=========================================

Name: temperature_calculator

Overview:
- Converts a sign-magnitude ADC sample into a signed temperature using a base coefficient and a reference divisor.
- Sits between the ADC interface and the SmartHome climate-control logic.
- Multi-cycle: one start/done handshake per conversion, with an iterative divider inside.

Parameters:
- DIV_CYCLES, 47: iterations of the restoring divider; equals the dividend width. Fixed value, not meant to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; samples the operands and launches a conversion.
- tc_base  in  32  unsigned base coefficient (multiplier).
- tc_ref  in  8  unsigned reference coefficient.
- adc_data  in  16  sign-magnitude sample: bit15 = sign (1 = negative), bits14:0 = magnitude.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when tempc is updated.
- div_zero  out  1  sticky until next start; set when tc_ref = 0.
- tempc  out  32  two's-complement temperature result, held between conversions.

Behaviour:
- Reset (async, rst_n low): tempc = 0, busy = 0, done = 0, div_zero = 0, FSM = IDLE.
  - Reset mid-conversion aborts the conversion and returns to these values.
- Formula: tempc = sign × trunc( (|adc| × tc_base) / (tc_ref × tc_ref) ).
  - Truncation is toward zero.
  - Sign is adc_data[15].
- Arithmetic widths:
  - numerator = 15b magnitude × 32b = 47-bit unsigned.
  - divisor = tc_ref² = 16-bit unsigned.
  - quotient is 47-bit unsigned.
- FSM states:
  - IDLE: wait for start. On start: register all inputs, go to MUL.
  - MUL: form numerator and divisor in one cycle, then go to DIV. If divisor = 0, go straight to OUT.
  - DIV: restoring division, one quotient bit per cycle, DIV_CYCLES cycles, then go to OUT.
  - OUT: apply sign and saturation, load tempc, pulse done, return to IDLE.
- Latency: start to done = 49 cycles (1 + 47 + 1); division-by-zero path = 2 cycles.
- busy is high from the cycle after start until the cycle done is asserted, inclusive.
- start while busy is ignored; operands are not re-sampled.
- start in the same cycle as done is ignored; it is accepted only from IDLE on the next cycle.
- Saturation:
  - quotient > 2^31−1: magnitude clamps to 2^31−1.
  - Negative results clamp to −(2^31−1).
  - −2^31 is never produced.
- Negative zero (adc_data = 16'h8000) or a zero product: tempc = 0, never negative.
- Division by zero (tc_ref = 0): div_zero = 1 and tempc = +(2^31−1) or −(2^31−1) according to the adc sign. Zero magnitude gives 0.
- Inputs may change freely after start; only the sampled copies are used.

Optional Feature:
- Macro TEMPC_ROUND_EN.
- Defined: the quotient rounds half away from zero. Add 1 to the magnitude when 2·remainder ≥ divisor, before saturation. Adds no cycles; rounding happens in OUT.
- Undefined: truncation toward zero, as above.

Test Plan:
- tc_base=6, tc_ref=6, adc=16'h800F, start → done after 49 cycles; tempc=32'hFFFFFFFE (−2), div_zero=0.
  - With TEMPC_ROUND_EN: tempc=−3.
- tc_base=100, tc_ref=2, adc=16'h0019 (+25) → tempc=625 (32'h00000271).
- tc_ref=0, adc=16'h8005 → done after 2 cycles; div_zero=1, tempc=32'h80000001.
  - Next valid start clears div_zero.
- tc_base=32'hFFFFFFFF, tc_ref=1, adc=16'h7FFF → tempc=32'h7FFFFFFF (saturated).
  - adc=16'h8000 → tempc=0.
- Conversion in flight: pulse start again at cycle 10 with new operands → ignored; result matches the first operands.
  - Assert rst_n low at cycle 20 → tempc=0, busy=0 immediately; no done pulse.

Source files
------------

// File: rtl/temperature_calculator.sv
// Sign-magnitude ADC sample to signed temperature: |adc| * tc_base / tc_ref^2 via a restoring divider.
// Optional build macro TEMPC_ROUND_EN selects round-half-away-from-zero instead of truncation.
module temperature_calculator #(
  parameter int DIV_CYCLES = 47
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        tc_base,
  input  logic [7:0]         tc_ref,
  input  logic [15:0]        adc_data,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic signed [31:0] tempc
);

  localparam logic [47:0] MAG_MAX = 48'h0000_7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, MUL, DIV, OUT} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] base_q;
  logic [7:0]  ref_q;
  logic [14:0] mag_q;
  logic        sign_q;
  logic [46:0] quo;
  logic [15:0] rem;
  logic [15:0] den;
  logic [16:0] rem_sh;
  logic        rem_ge;
  logic [47:0] mag_rnd;
  logic [30:0] mag_out;
  logic signed [31:0] tempc_nxt;
  logic        start_ok;

`ifdef TEMPC_ROUND_EN
  function automatic logic [47:0] round_mag(input logic [46:0] q, input logic [15:0] r,
                                            input logic [15:0] d);
    logic [47:0] m;
    m = {1'b0, q};
    if ({r, 1'b0} >= {1'b0, d}) m = m + 48'd1;
    return m;
  endfunction
`else
  function automatic logic [47:0] round_mag(input logic [46:0] q);
    return {1'b0, q};
  endfunction
`endif

  function automatic logic [30:0] sat_mag(input logic [47:0] m);
    return (m > MAG_MAX) ? 31'h7FFF_FFFF : m[30:0];
  endfunction

  // A zero magnitude negates to zero, so negative zero cannot appear.
  function automatic logic signed [31:0] apply_sign(input logic neg, input logic [30:0] m);
    logic signed [31:0] v;
    v = signed'({1'b0, m});
    return neg ? -v : v;
  endfunction

  // A start coinciding with the done pulse is deliberately dropped.
  assign start_ok = (state == IDLE) && start && !done;

  always_comb begin
    rem_sh = {rem, quo[46]};
    rem_ge = rem_sh >= {1'b0, den};
`ifdef TEMPC_ROUND_EN
    mag_rnd = round_mag(quo, rem, den);
`else
    mag_rnd = round_mag(quo);
`endif
    if (div_zero) mag_out = (mag_q == 15'd0) ? 31'd0 : 31'h7FFF_FFFF;
    else          mag_out = sat_mag(mag_rnd);
    tempc_nxt = apply_sign(sign_q, mag_out);
  end

  // Datapath: operand capture, product formation, one quotient bit per DIV cycle
  always_ff @(posedge clk) begin
    if (start_ok) begin
      base_q <= tc_base;
      ref_q  <= tc_ref;
      mag_q  <= adc_data[14:0];
      sign_q <= adc_data[15];
    end
    case (state)
      MUL: begin
        quo <= 47'(mag_q) * 47'(base_q);
        den <= 16'(ref_q) * 16'(ref_q);
        rem <= 16'd0;
      end
      DIV: begin
        if (rem_ge) begin
          rem <= 16'(rem_sh - {1'b0, den});
          quo <= {quo[45:0], 1'b1};
        end else begin
          rem <= rem_sh[15:0];
          quo <= {quo[45:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      tempc    <= 32'sd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start_ok;
          if (start_ok) begin
            div_zero <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          cnt <= 6'd0;
          if (ref_q == 8'd0) begin
            div_zero <= 1'b1;
            state    <= OUT;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'(DIV_CYCLES - 1)) state <= OUT;
        end
        OUT: begin
          tempc <= tempc_nxt;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temperature_calculator.sv
// Randomized and directed bench for temperature_calculator against an arithmetic reference model.
module tb_temperature_calculator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [31:0]        tc_base = 32'd0;
  logic [7:0]         tc_ref = 8'd0;
  logic [15:0]        adc_data = 16'd0;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic signed [31:0] tempc;

  int errors = 0;
  int checks = 0;

  localparam longint unsigned MAXV = 64'h7FFF_FFFF;

  temperature_calculator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tc_base(tc_base), .tc_ref(tc_ref),
    .adc_data(adc_data), .busy(busy), .done(done), .div_zero(div_zero), .tempc(tempc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] b, input logic [7:0] r,
                                        input logic [15:0] a);
    longint unsigned mag, num, dv, q, rm;
    mag = a[14:0];
    num = mag * b;
    if (r == 8'd0) begin
      q = (mag == 0) ? 0 : MAXV;
    end else begin
      dv = r * r;
      q  = num / dv;
      rm = num % dv;
`ifdef TEMPC_ROUND_EN
      if (2 * rm >= dv) q = q + 1;
`endif
      if (q > MAXV) q = MAXV;
    end
    return a[15] ? 32'(64'd0 - q) : 32'(q);
  endfunction

  // Launches one conversion and waits (bounded) for done; optionally re-pulses start mid-flight.
  task automatic run_conv(input logic [31:0] b, input logic [7:0] r, input logic [15:0] a,
                          input int restart_at, output int lat, output logic busy_ok,
                          output logic tmo);
    @(negedge clk);
    tc_base = b; tc_ref = r; adc_data = a; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    tc_base = $urandom; tc_ref = 8'($urandom); adc_data = 16'($urandom);
    busy_ok = busy;
    lat = 0;
    tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      start = (lat == restart_at);
      if (start) begin
        tc_base = $urandom; tc_ref = 8'($urandom_range(1, 255)); adc_data = 16'($urandom);
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || tempc !== 32'sd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b tempc=%h expected 0 0 0 00000000",
               busy, done, div_zero, tempc);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_vectors();
    int lat; logic bok, tmo;
    logic [31:0] exp_v;
`ifdef TEMPC_ROUND_EN
    exp_v = 32'hFFFF_FFFD;
`else
    exp_v = 32'hFFFF_FFFE;
`endif
    run_conv(32'd6, 8'd6, 16'h800F, 0, lat, bok, tmo);
    checks++;
    if (tmo || lat != 49 || !bok) begin
      errors++;
      $display("FAIL neg_small_timing: got lat=%0d busy_ok=%b tmo=%b expected lat=49 busy_ok=1 tmo=0",
               lat, bok, tmo);
    end
    checks++;
    if (tempc !== exp_v || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL neg_small_value: got tempc=%h dz=%b expected %h 0", tempc, div_zero, exp_v);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b busy=%b expected 0 0", done, busy);
    end
    run_conv(32'd100, 8'd2, 16'h0019, 0, lat, bok, tmo);
    checks++;
    if (tmo || tempc !== 32'sd625) begin
      errors++;
      $display("FAIL pos_625: got tempc=%h tmo=%b expected 00000271 0", tempc, tmo);
    end
    run_conv(32'hFFFF_FFFF, 8'd1, 16'h7FFF, 0, lat, bok, tmo);
    checks++;
    if (tmo || tempc !== 32'sh7FFF_FFFF) begin
      errors++;
      $display("FAIL sat_pos: got tempc=%h expected 7fffffff", tempc);
    end
    run_conv(32'hFFFF_FFFF, 8'd1, 16'hFFFF, 0, lat, bok, tmo);
    checks++;
    if (tmo || tempc !== 32'sh8000_0001) begin
      errors++;
      $display("FAIL sat_neg: got tempc=%h expected 80000001", tempc);
    end
    run_conv(32'hFFFF_FFFF, 8'd1, 16'h8000, 0, lat, bok, tmo);
    checks++;
    if (tmo || tempc !== 32'sd0) begin
      errors++;
      $display("FAIL neg_zero: got tempc=%h expected 00000000", tempc);
    end
  endtask

  task automatic test_div_zero();
    int lat; logic bok, tmo;
    run_conv(32'd1234, 8'd0, 16'h8005, 0, lat, bok, tmo);
    checks++;
    if (tmo || lat != 2 || !bok || div_zero !== 1'b1 || tempc !== 32'sh8000_0001) begin
      errors++;
      $display("FAIL dz_neg: got lat=%0d busy_ok=%b dz=%b tempc=%h expected 2 1 1 80000001",
               lat, bok, div_zero, tempc);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (div_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_sticky: got dz=%b expected 1", div_zero);
    end
    run_conv(32'd7, 8'd0, 16'h0005, 0, lat, bok, tmo);
    checks++;
    if (tmo || div_zero !== 1'b1 || tempc !== 32'sh7FFF_FFFF) begin
      errors++;
      $display("FAIL dz_pos: got dz=%b tempc=%h expected 1 7fffffff", div_zero, tempc);
    end
    run_conv(32'd7, 8'd0, 16'h8000, 0, lat, bok, tmo);
    checks++;
    if (tmo || div_zero !== 1'b1 || tempc !== 32'sd0) begin
      errors++;
      $display("FAIL dz_zero_mag: got dz=%b tempc=%h expected 1 00000000", div_zero, tempc);
    end
    run_conv(32'd9, 8'd3, 16'h0004, 0, lat, bok, tmo);
    checks++;
    if (tmo || div_zero !== 1'b0 || tempc !== 32'sd4) begin
      errors++;
      $display("FAIL dz_clear: got dz=%b tempc=%h expected 0 00000004", div_zero, tempc);
    end
  endtask

  task automatic test_random();
    int lat; logic bok, tmo;
    logic [31:0] b; logic [7:0] r; logic [15:0] a; logic [31:0] exp_v;
    for (int n = 0; n < 30; n++) begin
      b = $urandom;
      r = (n % 5 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(1, 255));
      a = 16'($urandom);
      if (n % 7 == 3) a[14:0] = 15'($urandom_range(0, 3));
      exp_v = model(b, r, a);
      run_conv(b, r, a, 0, lat, bok, tmo);
      checks++;
      if (tmo || tempc !== exp_v || div_zero !== (r == 8'd0) || lat != ((r == 8'd0) ? 2 : 49)) begin
        errors++;
        $display("FAIL random_%0d: b=%h r=%h a=%h got tempc=%h dz=%b lat=%0d expected %h %b %0d",
                 n, b, r, a, tempc, div_zero, lat, exp_v, (r == 8'd0), (r == 8'd0) ? 2 : 49);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic bok, tmo;
    logic [31:0] exp_v;
    exp_v = model(32'd5000, 8'd7, 16'h9234);
    run_conv(32'd5000, 8'd7, 16'h9234, 10, lat, bok, tmo);
    checks++;
    if (tmo || lat != 49 || !bok || tempc !== exp_v) begin
      errors++;
      $display("FAIL busy_ignore: got tempc=%h lat=%0d busy_ok=%b expected %h 49 1",
               tempc, lat, bok, exp_v);
    end
  endtask

  task automatic test_done_cycle_start();
    int lat; logic bok, tmo;
    logic [31:0] exp_v;
    run_conv(32'd77, 8'd3, 16'h0100, 0, lat, bok, tmo);
    tc_base = 32'd1; tc_ref = 8'd1; adc_data = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle_start: got busy=%b done=%b expected 0 0", busy, done);
    end
    exp_v = model(32'd300, 8'd5, 16'h8123);
    run_conv(32'd300, 8'd5, 16'h8123, 0, lat, bok, tmo);
    checks++;
    if (tmo || lat != 49 || tempc !== exp_v) begin
      errors++;
      $display("FAIL back_to_back: got tempc=%h lat=%0d expected %h 49", tempc, lat, exp_v);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(negedge clk);
    tc_base = 32'd999; tc_ref = 8'd2; adc_data = 16'h0321; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tempc !== 32'sd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midflight: got tempc=%h busy=%b done=%b expected 00000000 0 0",
               tempc, busy, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d active cycles after reset expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_div_zero();
    test_random();
    test_busy_ignore();
    test_done_cycle_start();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
